// File: rtl/serial_parity_checker_if.sv
// Bit-serial frame bus for serial_parity_checker; err_count exists only with SERIAL_PARITY_ERR_COUNT_EN.
// master drives the serial stream and controls, slave returns the frame status.
interface serial_parity_checker_if #(
    parameter int CNT_W = 8
);
    logic x;
    logic x_valid;
    logic odd_mode;
    logic abort;
    logic z;
    logic busy;
    logic frame_done;
    logic parity_err;
`ifdef SERIAL_PARITY_ERR_COUNT_EN
    logic [CNT_W-1:0] err_count;
`else
    wire w_unused_cnt_w = |CNT_W;
`endif

    modport master (
`ifdef SERIAL_PARITY_ERR_COUNT_EN
        input  err_count,
`endif
        output x, x_valid, odd_mode, abort,
        input  z, busy, frame_done, parity_err
    );

    modport slave (
`ifdef SERIAL_PARITY_ERR_COUNT_EN
        output err_count,
`endif
        input  x, x_valid, odd_mode, abort,
        output z, busy, frame_done, parity_err
    );
endinterface

// File: rtl/serial_parity_checker.sv
// Serial frame parity checker: WORD_LEN data bits + 1 parity bit, one-cycle frame_done/parity_err pulse.
// Optional saturating error counter selected by SERIAL_PARITY_ERR_COUNT_EN.
module serial_parity_checker #(
    parameter int WORD_LEN = 8,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_parity_checker_if.slave bus
);
    localparam int              CW   = $clog2(WORD_LEN + 1);
    localparam logic [CW-1:0]   LAST = CW'(WORD_LEN);

    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_count, w_count_nxt, w_count_inc;
    logic          r_z, w_z_nxt;
    logic          r_mode, w_mode_nxt;
    logic          r_frame_done, w_done_nxt;
    logic          r_parity_err, w_perr_nxt;

    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_z          <= 1'b0;
            r_mode       <= 1'b0;
            r_frame_done <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_z          <= w_z_nxt;
            r_mode       <= w_mode_nxt;
            r_frame_done <= w_done_nxt;
            r_parity_err <= w_perr_nxt;
        end
    end

    // Abort wins over a concurrent valid bit; in IDLE it simply drops that bit.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_z_nxt     = r_z;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        w_perr_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.x_valid && !bus.abort) begin
                    w_z_nxt     = bus.x;
                    w_mode_nxt  = bus.odd_mode;
                    w_count_nxt = CW'(1);
                    w_state_nxt = (WORD_LEN == 1) ? PAR : DATA;
                end
            end
            DATA: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                    w_z_nxt     = 1'b0;
                end else if (bus.x_valid) begin
                    w_z_nxt     = r_z ^ bus.x;
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == LAST) begin
                        w_state_nxt = PAR;
                    end
                end
            end
            PAR: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                    w_z_nxt     = 1'b0;
                end else if (bus.x_valid) begin
                    w_perr_nxt  = bus.x ^ r_z ^ r_mode;
                    w_done_nxt  = 1'b1;
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign bus.z          = r_z;
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = r_frame_done;
    assign bus.parity_err = r_parity_err;

`ifdef SERIAL_PARITY_ERR_COUNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_perr_nxt && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign bus.err_count = r_err_count;
`else
    wire w_unused_cnt_w = |CNT_W;
`endif
endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker (WORD_LEN=4, CNT_W=2): frame table plus abort/reset/saturation sequences.
module tb_serial_parity_checker;
    localparam int WL = 4;
    localparam int CW = 2;

    typedef struct {
        logic       odd;
        logic [3:0] data;     // data[i] is the i-th bit sent
        logic       par;
        int         gap;
        logic       exp_err;
        logic       exp_z;
    } vec_t;

    typedef struct {
        logic err;
        logic z;
        int   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   model_cnt = 0;
    exp_t sb[$];
    vec_t tbl[8];
    vec_t bad_v;
    vec_t good_v;
    int   exp_seq[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_parity_checker_if #(.CNT_W(CW)) bus();

    serial_parity_checker #(.WORD_LEN(WL), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic m);
        bus.x        = b;
        bus.x_valid  = 1'b1;
        bus.odd_mode = m;
        @(posedge clk);
        #1;
        bus.x_valid  = 1'b0;
        bus.x        = 1'b0;
    endtask

    // odd_mode is inverted after the first bit; only the first bit's value may matter.
    task automatic send_frame(input vec_t v);
        for (int i = 0; i < WL; i++) begin
            if (i > 0) idle(v.gap);
            send_bit(v.data[i], (i == 0) ? v.odd : ~v.odd);
        end
        idle(v.gap);
        send_bit(v.par, ~v.odd);
        sb.push_back('{v.exp_err, v.exp_z, cyc});
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            model_cnt = 0;
        end else if (bus.frame_done) begin
            if (sb.size() == 0) begin
                check("spurious_frame_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_latency", cyc, e.cyc);
                check("parity_err", bus.parity_err, e.err);
                check("z_at_done", bus.z, e.z);
                if (e.err && model_cnt < 3) model_cnt = model_cnt + 1;
`ifdef SERIAL_PARITY_ERR_COUNT_EN
                check("err_count", bus.err_count, model_cnt);
`endif
            end
        end else begin
            check("parity_err_quiet", bus.parity_err, 1'b0);
        end
    end

    initial begin
        tbl[0] = '{1'b0, 4'b1101, 1'b1, 0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 4'b1101, 1'b0, 0, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 4'b0011, 1'b1, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 4'b1101, 1'b1, 1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 4'b1101, 1'b1, 3, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 4'b0000, 1'b0, 0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 4'b0110, 1'b0, 2, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 4'b0111, 1'b1, 0, 1'b1, 1'b1};
        good_v  = tbl[0];
        bad_v   = tbl[1];
        exp_seq = '{1, 2, 3, 3, 3};

        bus.x = 1'b0; bus.x_valid = 1'b0; bus.odd_mode = 1'b0; bus.abort = 1'b0;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_z", bus.z, 1'b0);
        check("rst_done", bus.frame_done, 1'b0);
        check("rst_perr", bus.parity_err, 1'b0);
`ifdef SERIAL_PARITY_ERR_COUNT_EN
        check("rst_err_count", bus.err_count, 0);
`endif
        @(posedge clk);
        #1;

        // Table frames run back to back: each next frame starts in the frame_done cycle.
        for (int k = 0; k < 8; k++) send_frame(tbl[k]);
        idle(3);
        check("z_hold_after_frame", bus.z, 1'b1);
        check("busy_idle", bus.busy, 1'b0);

        // Abort after two data bits.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("busy_in_frame", bus.busy, 1'b1);
        bus.abort = 1'b1; bus.x_valid = 1'b1; bus.x = 1'b1;
        idle(1);
        bus.abort = 1'b0; bus.x_valid = 1'b0; bus.x = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_z", bus.z, 1'b0);
        send_frame(good_v);

        // Abort while waiting for the parity bit.
        for (int i = 0; i < WL; i++) send_bit(good_v.data[i], 1'b0);
        bus.abort = 1'b1; bus.x_valid = 1'b1; bus.x = 1'b1;
        idle(1);
        bus.abort = 1'b0; bus.x_valid = 1'b0;
        check("abort_par_busy", bus.busy, 1'b0);

        // Abort in IDLE drops the concurrent bit.
        bus.abort = 1'b1; bus.x_valid = 1'b1; bus.x = 1'b1;
        idle(1);
        bus.abort = 1'b0; bus.x_valid = 1'b0; bus.x = 1'b0;
        check("abort_idle_busy", bus.busy, 1'b0);
        send_frame(good_v);

        // Reset after three data bits.
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_z", bus.z, 1'b0);
        check("midrst_done", bus.frame_done, 1'b0);
        check("midrst_perr", bus.parity_err, 1'b0);
`ifdef SERIAL_PARITY_ERR_COUNT_EN
        check("midrst_err_count", bus.err_count, 0);
`endif
        send_frame(good_v);

        // Five bad frames in a row: counter saturates.
        for (int k = 0; k < 5; k++) begin
            send_frame(bad_v);
`ifdef SERIAL_PARITY_ERR_COUNT_EN
            check("err_count_seq", bus.err_count, exp_seq[k]);
`endif
        end

        idle(4);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
